// File: rtl/blit_loop_seq.sv
// ---------------------------------------------------------------------------
// blit_loop_seq
// Outer/inner loop sequencer for the blitter. Holds the GPU-loaded outer and
// inner loop counts and runs the inner loop one handshaked iteration at a
// time. It pulses outer_step at the end of each inner pass, then decrements
// the outer count. It reports done when the outer count is exhausted.
//
// Ports
//   sys_clk     in   system clock, all state on rising edge
//   reset       in   asynchronous active-high reset
//   gpu_din     in   [31:16] outer count, [15:0] inner count
//   countld     in   load both counts from gpu_din (IDLE only)
//   go          in   start a run (IDLE only)
//   stop        in   abort to IDLE from any state, counts are kept
//   step_req    out  inner-iteration request to the datapath
//   step_ack    in   datapath accepts one inner iteration
//   outer_step  out  one-cycle pulse at the end of each inner pass
//   busy        out  high in RUN and OSTEP
//   done        out  one-cycle pulse on normal completion
//   ocount      out  remaining outer count
//   icount      out  remaining inner iterations in the current pass
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for countld / go
// RUN   | step_req high, one icount decrement per accepted step_ack
// OSTEP | one-cycle inner-pass boundary, outer_step high, ocount decrements
// DONE  | one-cycle completion pulse, returns to IDLE
// ---------------------------------------------------------------------------
module blit_loop_seq (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic [31:0] gpu_din,
    input  logic        countld,
    input  logic        go,
    input  logic        stop,
    output logic        step_req,
    input  logic        step_ack,
    output logic        outer_step,
    output logic        busy,
    output logic        done,
    output logic [15:0] ocount,
    output logic [15:0] icount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        OSTEP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] inner_ld;

    // A go coincident with countld must see the freshly written counts.
    logic [15:0] ocount_src;
    logic [15:0] inner_src;
    logic        zero_go;

    assign ocount_src = countld ? gpu_din[31:16] : ocount;
    assign inner_src  = countld ? gpu_din[15:0]  : inner_ld;
    assign zero_go    = (ocount_src == 16'd0) || (inner_src == 16'd0);

    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        state_nxt = zero_go ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (step_ack && (icount == 16'd1)) begin
                        state_nxt = OSTEP;
                    end
                end
                OSTEP: begin
                    state_nxt = (ocount == 16'd1) ? DONE : RUN;
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up exactly
    // with the state register and never see an input combinationally.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            step_req   <= 1'b0;
            outer_step <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ocount     <= 16'd0;
            icount     <= 16'd0;
            inner_ld   <= 16'd0;
        end else begin
            state      <= state_nxt;
            step_req   <= (state_nxt == RUN);
            outer_step <= (state_nxt == OSTEP);
            busy       <= (state_nxt == RUN) || (state_nxt == OSTEP);
            done       <= (state_nxt == DONE);

            // stop wins over every other request, including a coincident ack.
            if (!stop) begin
                case (state)
                    IDLE: begin
                        if (countld) begin
                            inner_ld <= gpu_din[15:0];
                            ocount   <= gpu_din[31:16];
                            icount   <= gpu_din[15:0];
                        end
                        if (go && !zero_go) begin
                            icount <= inner_src;
                        end
                    end
                    RUN: begin
                        if (step_ack) begin
                            icount <= icount - 16'd1;
                        end
                    end
                    OSTEP: begin
                        ocount <= ocount - 16'd1;
                        if (ocount != 16'd1) begin
                            icount <= inner_ld;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_blit_loop_seq.sv
module tb_blit_loop_seq;

    logic        sys_clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] gpu_din = 32'd0;
    logic        countld = 1'b0;
    logic        go = 1'b0;
    logic        stop = 1'b0;
    logic        step_ack = 1'b0;
    logic        step_req;
    logic        outer_step;
    logic        busy;
    logic        done;
    logic [15:0] ocount;
    logic [15:0] icount;

    blit_loop_seq dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .gpu_din    (gpu_din),
        .countld    (countld),
        .go         (go),
        .stop       (stop),
        .step_req   (step_req),
        .step_ack   (step_ack),
        .outer_step (outer_step),
        .busy       (busy),
        .done       (done),
        .ocount     (ocount),
        .icount     (icount)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Expected observable events: 0 = accepted ack, 1 = outer_step, 2 = done.
    // oc/ic are the readback values during that cycle, cyc the absolute cycle.
    typedef struct {
        int kind;
        int cyc;
        int oc;
        int ic;
    } ev_t;

    ev_t sb[$];
    int  nvec = 0;
    int  nerr = 0;
    int  k;

    task automatic push_ev(input int kind, input int c, input int oc, input int ic);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.oc   = oc;
        e.ic   = ic;
        sb.push_back(e);
    endtask

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input logic [31:0] v);
        gpu_din = v;
        countld = 1'b1;
        tick;
        countld = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            tick;
            n++;
        end
        check({name, " all expected events seen"}, sb.size(), 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows an event.
    always @(negedge sys_clk) begin
        int  kind;
        ev_t e;
        if (!reset) begin
            kind = -1;
            if (done) kind = 2;
            else if (outer_step) kind = 1;
            else if (step_req && step_ack && !stop) kind = 0;
            if (kind >= 0) begin
                nvec++;
                if (sb.size() == 0) begin
                    nerr++;
                    $display("FAIL unexpected event: kind=%0d cyc=%0d oc=%0d ic=%0d, expected none",
                             kind, cyc, ocount, icount);
                end else begin
                    e = sb.pop_front();
                    if (e.kind != kind || e.cyc != cyc || e.oc != int'(ocount) || e.ic != int'(icount)) begin
                        nerr++;
                        $display("FAIL event: got kind=%0d cyc=%0d oc=%0d ic=%0d, expected kind=%0d cyc=%0d oc=%0d ic=%0d",
                                 kind, cyc, ocount, icount, e.kind, e.cyc, e.oc, e.ic);
                    end
                end
            end
        end
    end

    initial begin
        // reset state
        @(posedge sys_clk);
        #1;
        check("reset step_req", step_req, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset outer_step", outer_step, 0);
        check("reset ocount", ocount, 0);
        check("reset icount", icount, 0);
        tick;
        reset = 1'b0;
        tick;

        // 2 x 3, ack held: outer_step on go-cycle+4 and +8, done on +9
        load(32'h0002_0003);
        k = cyc;
        go = 1'b1;
        step_ack = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 3; i++) push_ev(0, k + 1 + 4 * p + i, 2 - p, 3 - i);
            push_ev(1, k + 4 + 4 * p, 2 - p, 0);
        end
        push_ev(2, k + 9, 0, 0);
        tick;
        go = 1'b0;
        check("t1 step_req one cycle after go", step_req, 1);
        check("t1 busy after go", busy, 1);
        drain("t1");
        step_ack = 1'b0;
        tick;
        check("t1 final ocount", ocount, 0);
        check("t1 final icount", icount, 0);
        check("t1 busy after done", busy, 0);

        // 1 x 4, ack every 3rd cycle; step_req must hold between acks
        load(32'h0001_0004);
        k = cyc;
        go = 1'b1;
        for (int i = 0; i < 4; i++) push_ev(0, k + 3 + 3 * i, 1, 4 - i);
        push_ev(1, k + 13, 1, 0);
        push_ev(2, k + 14, 0, 0);
        for (int j = 1; j <= 15; j++) begin
            tick;
            go = 1'b0;
            step_ack = ((j % 3) == 0) && (j <= 12);
            if (j <= 12) check("t2 step_req held", step_req, 1);
        end
        step_ack = 1'b0;
        drain("t2");
        check("t2 final icount", icount, 0);

        // zero outer count: done next cycle, nothing else moves
        load(32'h0000_0005);
        k = cyc;
        go = 1'b1;
        push_ev(2, k + 1, 0, 5);
        for (int j = 1; j <= 3; j++) begin
            tick;
            go = 1'b0;
            check("t3 busy stays low", busy, 0);
            check("t3 step_req stays low", step_req, 0);
            check("t3 ocount stays 0", ocount, 0);
        end
        drain("t3");

        // 3 x 2, stop with a coincident ack right after the 3rd ack
        load(32'h0003_0002);
        k = cyc;
        go = 1'b1;
        step_ack = 1'b1;
        push_ev(0, k + 1, 3, 2);
        push_ev(0, k + 2, 3, 1);
        push_ev(1, k + 3, 3, 0);
        push_ev(0, k + 4, 2, 2);
        for (int j = 1; j <= 5; j++) begin
            tick;
            go = 1'b0;
            if (j == 5) stop = 1'b1;
        end
        tick;
        stop = 1'b0;
        step_ack = 1'b0;
        check("t4 busy after stop", busy, 0);
        check("t4 step_req after stop", step_req, 0);
        check("t4 ocount after stop", ocount, 2);
        check("t4 icount after stop", icount, 1);
        check("t4 no done on stop", done, 0);
        tick;
        tick;
        drain("t4");

        // countld while busy is ignored
        load(32'h0001_0003);
        k = cyc;
        go = 1'b1;
        step_ack = 1'b1;
        for (int i = 0; i < 3; i++) push_ev(0, k + 1 + i, 1, 3 - i);
        push_ev(1, k + 4, 1, 0);
        push_ev(2, k + 5, 0, 0);
        tick;
        go = 1'b0;
        gpu_din = 32'h0001_0001;
        countld = 1'b1;
        tick;
        countld = 1'b0;
        check("t5 ocount unchanged by busy load", ocount, 1);
        check("t5 icount unchanged by busy load", icount, 2);
        drain("t5");
        step_ack = 1'b0;

        // countld and go together use the new counts
        tick;
        gpu_din = 32'h0001_0002;
        countld = 1'b1;
        go = 1'b1;
        step_ack = 1'b1;
        k = cyc;
        push_ev(0, k + 1, 1, 2);
        push_ev(0, k + 2, 1, 1);
        push_ev(1, k + 3, 1, 0);
        push_ev(2, k + 4, 0, 0);
        tick;
        countld = 1'b0;
        go = 1'b0;
        drain("t6");
        step_ack = 1'b0;

        // asynchronous reset mid-RUN
        load(32'h0002_0002);
        go = 1'b1;
        tick;
        go = 1'b0;
        tick;
        check("t7 step_req before reset", step_req, 1);
        #2;
        reset = 1'b1;
        #1;
        check("t7 async step_req", step_req, 0);
        check("t7 async busy", busy, 0);
        check("t7 async outer_step", outer_step, 0);
        check("t7 async done", done, 0);
        check("t7 async ocount", ocount, 0);
        check("t7 async icount", icount, 0);
        tick;
        tick;
        reset = 1'b0;
        // inner_ld was cleared too, so a bare go completes at once
        k = cyc;
        go = 1'b1;
        push_ev(2, k + 1, 0, 0);
        tick;
        go = 1'b0;
        check("t7 no busy after reset go", busy, 0);
        drain("t7");
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
